// File: rtl/fifo_uart_tx_sched.sv
// UART transmit scheduler: pops bytes from a FIFO and serialises them LSB-first as 8N1,
// with a shared oversample tick. Define FIFO_UART_TX_SCHED_PARITY_EN for 8E1 framing.
module fifo_uart_tx_sched #(
  parameter int CLK_IN     = 120000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tick,
  output logic       done
);

  localparam int DIV   = CLK_IN / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int OS_W  = (OVERSAMPLE < 2) ? 1 : $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("fifo_uart_tx_sched: CLK_IN/(BAUD*OVERSAMPLE) must be at least 2");
    end
    if (OVERSAMPLE < 2) begin : g_bad_os
      $error("fifo_uart_tx_sched: OVERSAMPLE must be at least 2");
    end
  endgenerate

`ifdef FIFO_UART_TX_SCHED_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              tick_q, tick_d;
  logic              done_q, done_d;
  logic              bit_end;
`ifdef FIFO_UART_TX_SCHED_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // The pop strobe must land in the same IDLE cycle the request is seen, so it is a
  // decode of state plus live inputs; reset blocks it so no byte is popped under reset.
  assign fifo_rd_en = !rst && (state_q == S_IDLE) && tx_en && !fifo_empty;
  assign busy       = busy_q || fifo_rd_en;
  assign tx         = tx_q;
  assign tick       = tick_q;
  assign done       = done_q;

  // tick_q always mirrors (div_cnt_q == DIV_LAST), so it doubles as the internal enable.
  assign bit_end = tick_q && (bit_cnt_q == OS_LAST);

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
    state_d   = state_q;
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
`ifdef FIFO_UART_TX_SCHED_PARITY_EN
    parity_d  = parity_q;
`endif

    if (state_q != S_IDLE && state_q != S_FETCH && tick_q) begin
      bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (fifo_rd_en) state_d = S_FETCH;
      end
      S_FETCH: begin
        shift_d   = fifo_dout;
`ifdef FIFO_UART_TX_SCHED_PARITY_EN
        parity_d  = ^fifo_dout;
`endif
        div_cnt_d = '0;  // start bit begins on tick phase 0
        bit_cnt_d = '0;
        idx_d     = '0;
        state_d   = S_START;
      end
      S_START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_SCHED_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef FIFO_UART_TX_SCHED_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are computed from next-state values so the registered copies line up with state_q.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
`ifdef FIFO_UART_TX_SCHED_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
    tick_d = (div_cnt_d == DIV_LAST);
    done_d = (state_d == S_STOP) && (div_cnt_d == DIV_LAST) && (bit_cnt_d == OS_LAST);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef FIFO_UART_TX_SCHED_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
`ifdef FIFO_UART_TX_SCHED_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx_sched.sv
// Self-checking bench for fifo_uart_tx_sched with CLK_IN=160, BAUD=1, OVERSAMPLE=16 (DIV=10).
// Define FIFO_UART_TX_SCHED_PARITY_EN to exercise 8E1 framing.
module tb_fifo_uart_tx_sched;

  localparam int CLK_IN  = 160;
  localparam int BAUD    = 1;
  localparam int OS      = 16;
  localparam int BIT_CYC = 160;
`ifdef FIFO_UART_TX_SCHED_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BIT_CYC;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic       tx_en  = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en, tx, busy, tick, done;

  logic [7:0] mem [0:63];
  logic [5:0] wr_ptr = '0;
  logic [5:0] rd_ptr = '0;
  logic       ovr_en  = 1'b0;
  logic       ovr_val = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int pop_cnt     = 0;
  int illegal_cnt = 0;
  logic prev_rd   = 1'b0;

  assign fifo_empty = ovr_en ? ovr_val : (rd_ptr == wr_ptr);

  fifo_uart_tx_sched #(.CLK_IN(CLK_IN), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .tick       (tick),
    .done       (done)
  );

  always #5 clk_in = ~clk_in;

  // FIFO model with one-cycle read latency, plus pop-protocol monitor
  always @(posedge clk_in) begin
    illegal_cnt <= illegal_cnt + int'(fifo_rd_en && fifo_empty) + int'(fifo_rd_en && prev_rd);
    prev_rd     <= fifo_rd_en;
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 6'd1;
      pop_cnt   <= pop_cnt + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef FIFO_UART_TX_SCHED_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic wait_start(output int waited);
    waited = -1;
    for (int i = 0; i < 500; i++) begin
      if (tx === 1'b0) begin
        waited = i;
        return;
      end
      @(negedge clk_in);
    end
  endtask

  // Checks a whole frame cycle by cycle; returns waiting time to the start bit and the bit-9 sample
  task automatic run_frame(input logic [7:0] b, input logic exp_busy_after, input int drop_at,
                           input string nm, output int waited, output logic par_seen);
    int mism, done_cnt, done_pos, busy_bad;
    mism = 0; done_cnt = 0; done_pos = -1; busy_bad = 0; par_seen = 1'b0;
    wait_start(waited);
    check({nm, "_start_seen"}, 32'(waited >= 0), 32'd1);
    if (waited < 0) return;
    for (int c = 0; c < FRAME; c++) begin
      if (tx !== exp_bit(b, c / BIT_CYC)) mism++;
      if (done === 1'b1) begin
        done_cnt++;
        done_pos = c;
      end
      if (busy !== 1'b1) busy_bad++;
      if (c == 9 * BIT_CYC + BIT_CYC / 2) par_seen = tx;
      if (c == drop_at) tx_en = 1'b0;
      @(negedge clk_in);
    end
    check({nm, "_bit_errors"}, mism, 0);
    check({nm, "_done_count"}, done_cnt, 1);
    check({nm, "_done_pos"}, done_pos, FRAME - 1);
    check({nm, "_busy_gaps"}, busy_bad, 0);
    check({nm, "_after_busy_done"}, {busy, done}, {exp_busy_after, 1'b0});
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic       empty;
    logic [3:0] exp;   // {fifo_rd_en, busy, tx, done}
    string      nm;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int   w, p0, txlow, tick_mism;
    logic par;

    vecs[0] = '{rst: 1'b1, en: 1'b1, empty: 1'b0, exp: 4'b0010, nm: "vec_reset_blocks_pop"};
    vecs[1] = '{rst: 1'b0, en: 1'b0, empty: 1'b0, exp: 4'b0010, nm: "vec_disabled"};
    vecs[2] = '{rst: 1'b0, en: 1'b1, empty: 1'b1, exp: 4'b0010, nm: "vec_empty"};
    vecs[3] = '{rst: 1'b0, en: 1'b0, empty: 1'b1, exp: 4'b0010, nm: "vec_idle_all_low"};
    vecs[4] = '{rst: 1'b0, en: 1'b1, empty: 1'b0, exp: 4'b1110, nm: "vec_pop"};

    repeat (3) @(negedge clk_in);

    // IDLE decision table; DUT is reset back to IDLE before each vector
    for (int i = 0; i < 5; i++) begin
      rst = 1'b1; tx_en = 1'b0; ovr_en = 1'b1; ovr_val = 1'b1;
      @(negedge clk_in);
      rst = vecs[i].rst; tx_en = vecs[i].en; ovr_val = vecs[i].empty;
      #1;
      check(vecs[i].nm, {fifo_rd_en, busy, tx, done}, vecs[i].exp);
      @(negedge clk_in);
    end

    // Reset state and free-running tick
    rst = 1'b1; tx_en = 1'b0; ovr_en = 1'b0;
    @(negedge clk_in);
    check("reset_state", {tx, busy, tick, done, fifo_rd_en}, 5'b10000);
    rst = 1'b0;
    tick_mism = 0; txlow = 0; p0 = pop_cnt;
    for (int i = 0; i < 50; i++) begin
      if (tick !== ((i % 10) == 9)) tick_mism++;
      if (tx !== 1'b1) txlow++;
      @(negedge clk_in);
    end
    check("tick_period_10", tick_mism, 0);
    check("idle_tx_high", txlow, 0);
    check("idle_no_pop", pop_cnt - p0, 0);

    // Single byte 0xA5
    p0 = pop_cnt;
    push(8'hA5); tx_en = 1'b1;
    #1;
    check("a5_pop_cycle", {fifo_rd_en, busy, tx}, 3'b111);
    @(negedge clk_in);
    check("a5_fetch_cycle", {fifo_rd_en, busy, tx}, 3'b011);
    run_frame(8'hA5, 1'b0, -1, "a5", w, par);
    check("a5_pop_count", pop_cnt - p0, 1);

    // Back-to-back 0x00, 0xFF
    p0 = pop_cnt;
    push(8'h00); push(8'hFF);
    run_frame(8'h00, 1'b1, -1, "b2b_0", w, par);
    run_frame(8'hFF, 1'b0, -1, "b2b_1", w, par);
    check("b2b_gap", w, 2);
    check("b2b_pop_count", pop_cnt - p0, 2);

    // tx_en gating, then drop mid-frame
    tx_en = 1'b0;
    p0 = pop_cnt;
    push(8'h11); push(8'h22); push(8'h33);
    txlow = 0;
    repeat (300) begin
      if (tx !== 1'b1) txlow++;
      @(negedge clk_in);
    end
    check("en_low_no_pop", pop_cnt - p0, 0);
    check("en_low_tx_high", txlow, 0);
    tx_en = 1'b1;
    run_frame(8'h11, 1'b1, -1, "en_b1", w, par);
    run_frame(8'h22, 1'b0, 800, "en_b2", w, par);
    txlow = 0;
    repeat (400) begin
      if (tx !== 1'b1) txlow++;
      @(negedge clk_in);
    end
    check("en_drop_pop_count", pop_cnt - p0, 2);
    check("en_drop_tx_high", txlow, 0);
    check("en_drop_byte3_queued", 32'(wr_ptr - rd_ptr), 32'd1);

    // Reset during data bit 3 of 0x33, then 0x44 follows
    p0 = pop_cnt;
    push(8'h44); tx_en = 1'b1;
    wait_start(w);
    check("rst_start_gap", w, 2);
    repeat (4 * BIT_CYC + BIT_CYC / 2) @(negedge clk_in);
    check("rst_pre_bit3", tx, 1'b0);
    rst = 1'b1;
    @(negedge clk_in);
    check("rst_abort", {tx, busy, done, fifo_rd_en}, 4'b1000);
    rst = 1'b0;
    run_frame(8'h44, 1'b0, -1, "rst_next", w, par);
    check("rst_pop_count", pop_cnt - p0, 2);
    check("rst_fifo_drained", 32'(wr_ptr - rd_ptr), 32'd0);

`ifdef FIFO_UART_TX_SCHED_PARITY_EN
    push(8'h07); push(8'h03);
    run_frame(8'h07, 1'b1, -1, "par_07", w, par);
    check("par_07_bit", par, 1'b1);
    run_frame(8'h03, 1'b0, -1, "par_03", w, par);
    check("par_03_bit", par, 1'b0);
`endif

    @(negedge clk_in);
    check("pop_protocol_violations", illegal_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx_sched.md
Name: fifo_uart_tx_sched

Overview:
Transmit scheduler between the byte FIFO and the serial line. Generates its own oversample tick enable from clk_in; no derived clock leaves the block. Pops one byte at a time from the FIFO and serialises it LSB-first as 8N1, with optional parity. Holds the line idle high whenever the FIFO is empty or transmission is disabled.

Parameters:
CLK_IN, 120000000, input clock frequency in Hz.
BAUD, 9600, line bit rate in bits per second.
OVERSAMPLE, 16, number of ticks per bit. Tick output is shared with the RX side.

Ports:
clk_in  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
tx_en  input  1  level enable; sampled only in IDLE.
fifo_empty  input  1  FIFO empty flag.
fifo_dout  input  8  FIFO read data; valid the cycle after fifo_rd_en.
fifo_rd_en  output  1  single-cycle pop strobe.
tx  output  1  serial line; idle high.
busy  output  1  high from the pop cycle through the end of the stop bit.
tick  output  1  one-cycle oversample enable.
done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Tick divider: DIV = CLK_IN/(BAUD*OVERSAMPLE), integer truncation; default 781.
  - Counter width is $clog2(DIV) bits. It counts 0..DIV-1 and wraps.
  - tick=1 on the cycle the count equals DIV-1, giving a period of exactly DIV clk_in cycles.
  - The counter is forced to 0 on the cycle the FSM enters START, so the start-bit edge aligns to tick phase 0.
  - Elaboration must fail if DIV < 2.
- Reset (synchronous, held any number of cycles):
  - Outputs: tx=1, fifo_rd_en=0, busy=0, tick=0, done=0.
  - Internal: FSM=IDLE, all counters and the shift register cleared.
  - Reset asserted mid-frame aborts the frame immediately; tx returns high on the next edge; the popped byte is lost.
- FSM states: IDLE, FETCH, START, DATA, [PARITY], STOP.
  - IDLE: if tx_en && !fifo_empty, assert fifo_rd_en for exactly that cycle and go to FETCH; otherwise stay with tx=1.
  - FETCH: latch fifo_dout into the shift register (FIFO read latency is 1). Go to START.
  - START: tx=0 for OVERSAMPLE ticks. Go to DATA with bit index 0.
  - DATA: tx=shift[0] for OVERSAMPLE ticks, then shift right. After bit 7, go to PARITY if compiled in, otherwise STOP.
  - STOP: tx=1 for OVERSAMPLE ticks. done pulses on the tick that ends the bit. Go to IDLE.
- Bit timing: a per-bit tick counter of width $clog2(OVERSAMPLE) advances only on tick. The bit ends on the tick where it equals OVERSAMPLE-1. Each bit lasts OVERSAMPLE*DIV clk_in cycles.
- busy: high in FETCH through STOP, and in the IDLE cycle where fifo_rd_en=1.
- Back-to-back bytes: the IDLE cycle immediately after STOP may pop again. Inter-frame gap is 2 cycles (IDLE and FETCH) plus the START alignment; no extra idle bits.
- tx_en deasserted mid-frame: the current frame completes; no new pop.
- fifo_empty rising mid-frame: ignored; it is only sampled in IDLE.
- fifo_rd_en is never asserted while fifo_empty=1 or while busy from a previous pop.

Optional Feature:
- Macro: FIFO_UART_TX_SCHED_PARITY_EN.
- Defined: PARITY state inserted after DATA. tx = XOR of the 8 latched data bits (even parity) for OVERSAMPLE ticks; frame is 11 bits (8E1).
- Undefined: PARITY state, parity register and XOR logic are not generated; frame is 10 bits (8N1).

Test Plan:
1. Bench params CLK_IN=160, BAUD=1, OVERSAMPLE=16 (DIV=10). Run freely -> tick pulses every 10 cycles exactly.
2. Same params; push 0xA5 with tx_en=1 -> fifo_rd_en is 1 for one cycle. tx sequence is 0, then 1,0,1,0,0,1,0,1, then 1. Each bit lasts 160 cycles. done pulses once and busy falls the following cycle.
3. Push 0x00 and 0xFF back-to-back -> two pops. Second start bit falls within 2 cycles after the first STOP ends; no glitch on tx.
4. Hold tx_en=0 with 3 bytes queued -> no fifo_rd_en and tx=1. Raise tx_en -> all 3 bytes sent in order. Drop tx_en during byte 2 -> byte 2 completes and byte 3 stays queued.
5. Assert rst for 1 cycle during DATA bit 3 -> next edge shows tx=1, busy=0, FSM in IDLE. Next pop takes the following FIFO entry.
6. With FIFO_UART_TX_SCHED_PARITY_EN defined, send 0x07 -> parity bit is 1 and the frame is 11 bit-times (1760 cycles). Send 0x03 -> parity bit is 0.
